// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-master single-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned N_BYTES   = 4;
    localparam int unsigned ADDR_BITS = 13;
    localparam int unsigned N_BITS    = N_BYTES * 8;
    localparam int unsigned OFF_BITS  = $clog2(N_BYTES);
    localparam int unsigned ADDR_OFF  = OFF_BITS;
    localparam int unsigned MADDR_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } ram_arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } ram_arb_grant_t;

    // Captured request presented to the RAM port
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [N_BITS-1:0]    wdata;
        logic [N_BYTES-1:0]   byte_en;
        logic                 ren;
        logic                 wen;
    } ram_req_t;

endpackage

// File: rtl/ram_arb_req_reg.sv
// Captured-request register driving the RAM port; load takes a new request,
// clr drops the strobes while keeping address/data stable.
module ram_arb_req_reg
    import ram_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  logic     clr,
    input  ram_req_t d,
    output ram_req_t q
);

    // Request snapshot; load has priority over strobe clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (clr) begin
            q.ren <= 1'b0;
            q.wen <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master (imem/dmem) arbiter in front of a single-port SRAM.
// Optional macro RAM_ARB_RR_EN: round-robin on contention instead of
// fixed dmem-over-imem priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [MADDR_W-1:0]   imem_addr,
    input  logic                 imem_ren,
    output logic [N_BITS-1:0]    imem_rdata,
    output logic                 imem_busy,
    input  logic [MADDR_W-1:0]   dmem_addr,
    input  logic [N_BITS-1:0]    dmem_wdata,
    input  logic [N_BYTES-1:0]   dmem_byte_en,
    input  logic                 dmem_ren,
    input  logic                 dmem_wen,
    output logic [N_BITS-1:0]    dmem_rdata,
    output logic                 dmem_busy,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [N_BITS-1:0]    ram_wdata,
    output logic [N_BYTES-1:0]   ram_byte_en,
    output logic                 ram_ren,
    output logic                 ram_wen,
    input  logic [N_BITS-1:0]    ram_rdata,
    input  logic                 ram_busy
);

    localparam int unsigned HI_LSB = ADDR_OFF + ADDR_BITS;

    ram_arb_state_t state;
    ram_arb_state_t state_nxt;
    ram_arb_grant_t grant;
    ram_req_t       req_sel;
    ram_req_t       req_q;
    logic           req_i;
    logic           req_d;
    logic           load;
    logic           clr;
    logic           unused_addr_bits;

    assign req_i = imem_ren;
    assign req_d = dmem_ren | dmem_wen;

    // Byte offset and address bits beyond the RAM depth are intentionally dropped
    assign unused_addr_bits = ^{imem_addr[MADDR_W-1:HI_LSB], imem_addr[ADDR_OFF-1:0],
                                dmem_addr[MADDR_W-1:HI_LSB], dmem_addr[ADDR_OFF-1:0]};

`ifdef RAM_ARB_RR_EN
    ram_arb_grant_t last_grant;

    // Contention goes to whoever was not granted last; a lone requester wins
    always_comb begin
        grant = GNT_I;
        if (req_i && req_d) begin
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            grant = GNT_D;
        end
    end

    // Remember the most recent grant
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= GNT_I;
        end else if (state == IDLE && (req_i || req_d)) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: dmem always beats imem
    always_comb begin
        grant = req_d ? GNT_D : GNT_I;
    end
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant from IDLE, return on completion or winner abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_nxt = (grant == GNT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (!req_i || !ram_busy) begin
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                if (!req_d || !ram_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: capture selection, completion handshake, strobe clear
    always_comb begin
        imem_busy       = 1'b1;
        dmem_busy       = 1'b1;
        imem_rdata      = '0;
        dmem_rdata      = '0;
        load            = 1'b0;
        clr             = 1'b0;
        req_sel.addr    = imem_addr[ADDR_OFF +: ADDR_BITS];
        req_sel.wdata   = '0;
        req_sel.byte_en = '1;
        req_sel.ren     = 1'b1;
        req_sel.wen     = 1'b0;
        case (state)
            IDLE: begin
                load = req_i | req_d;
                if (grant == GNT_D) begin
                    req_sel.addr    = dmem_addr[ADDR_OFF +: ADDR_BITS];
                    req_sel.wdata   = dmem_wdata;
                    req_sel.byte_en = dmem_byte_en;
                    req_sel.ren     = dmem_ren & ~dmem_wen;
                    req_sel.wen     = dmem_wen;
                end
            end
            SERVE_I: begin
                if (!req_i) begin
                    clr = 1'b1;
                end else if (!ram_busy) begin
                    imem_busy  = 1'b0;
                    imem_rdata = ram_rdata;
                    clr        = 1'b1;
                end
            end
            SERVE_D: begin
                if (!req_d) begin
                    clr = 1'b1;
                end else if (!ram_busy) begin
                    dmem_busy  = 1'b0;
                    dmem_rdata = ram_rdata;
                    clr        = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase
    end

    ram_arb_req_reg u_req_reg (
        .clk   (CLK),
        .rst_n (nRST),
        .load  (load),
        .clr   (clr),
        .d     (req_sel),
        .q     (req_q)
    );

    assign ram_addr    = req_q.addr;
    assign ram_wdata   = req_q.wdata;
    assign ram_byte_en = req_q.byte_en;
    assign ram_ren     = req_q.ren;
    assign ram_wen     = req_q.wen;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port SRAM
// whose latency (lat) is changed per scenario. Adapts grant expectations
// to RAM_ARB_RR_EN.
module tb_ram_port_arbiter;

    logic        CLK;
    logic        nRST;
    logic [31:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_rdata;
    logic        imem_busy;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_rdata;
    logic        dmem_busy;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byte_en;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    int checks;
    int errors;
    int lat;
    int cnt;

    logic [31:0] mem [8192];
    bit          written [8192];

    ram_port_arbiter dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imem_addr    (imem_addr),
        .imem_ren     (imem_ren),
        .imem_rdata   (imem_rdata),
        .imem_busy    (imem_busy),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_byte_en (dmem_byte_en),
        .dmem_ren     (dmem_ren),
        .dmem_wen     (dmem_wen),
        .dmem_rdata   (dmem_rdata),
        .dmem_busy    (dmem_busy),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_byte_en  (ram_byte_en),
        .ram_ren      (ram_ren),
        .ram_wen      (ram_wen),
        .ram_rdata    (ram_rdata),
        .ram_busy     (ram_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Unwritten words read back as their own word address
    function automatic logic [31:0] rd_word(input logic [12:0] a);
        return written[a] ? mem[a] : {19'd0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM model: done once the request has been held lat+1 cycles
    always_comb begin
        ram_busy  = !((ram_ren || ram_wen) && (cnt >= lat + 1));
        ram_rdata = (!ram_busy && ram_ren) ? rd_word(ram_addr) : 32'd0;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt <= 0;
        else if (!(ram_ren || ram_wen) || !ram_busy) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(posedge CLK) begin
        if (nRST && !ram_busy && ram_wen) begin
            mem[ram_addr]     <= merge(rd_word(ram_addr), ram_wdata, ram_byte_en);
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for the selected master's busy to drop; cyc = -1 on timeout
    task automatic wait_done(input bit is_d, input int max, output int cyc);
        cyc = 0;
        forever begin
            tick();
            cyc++;
            if ((is_d ? dmem_busy : imem_busy) == 1'b0) return;
            if (cyc >= max) begin
                cyc = -1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        tick();
        tick();
        checks++; if (ram_addr !== 13'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
        checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", ram_ren, ram_wen); end
        checks++; if (ram_wdata !== 32'd0 || ram_byte_en !== 4'd0) begin errors++; $display("FAIL reset_wdata got %h/%h exp 0", ram_wdata, ram_byte_en); end
        checks++; if (imem_busy !== 1'b1 || dmem_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b%b exp 11", imem_busy, dmem_busy); end
        checks++; if (imem_rdata !== 32'd0 || dmem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", imem_rdata, dmem_rdata); end
        nRST = 1'b1;
        tick();
        checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", ram_ren); end
    endtask

    task automatic test_imem_read();
        lat = 0;
        imem_addr = 32'h0000_0010;
        imem_ren  = 1'b1;
        tick();
        checks++; if (ram_addr !== 13'h4) begin errors++; $display("FAIL ird_addr got %h exp 4", ram_addr); end
        checks++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0) begin errors++; $display("FAIL ird_strobe got %b%b exp 10", ram_ren, ram_wen); end
        checks++; if (imem_busy !== 1'b1) begin errors++; $display("FAIL ird_busy_c1 got %b exp 1", imem_busy); end
        tick();
        checks++; if (imem_busy !== 1'b0) begin errors++; $display("FAIL ird_done got %b exp 0", imem_busy); end
        checks++; if (imem_rdata !== 32'h4) begin errors++; $display("FAIL ird_data got %h exp 4", imem_rdata); end
        checks++; if (dmem_busy !== 1'b1 || dmem_rdata !== 32'd0) begin errors++; $display("FAIL ird_loser got %b/%h exp 1/0", dmem_busy, dmem_rdata); end
        tick();
        checks++; if (ram_ren !== 1'b0 || imem_busy !== 1'b1) begin errors++; $display("FAIL ird_bubble got %b/%b exp 0/1", ram_ren, imem_busy); end
        imem_ren = 1'b0;
    endtask

    task automatic test_write_read();
        int cyc;
        lat = 0;
        dmem_addr    = 32'h20;
        dmem_wdata   = 32'hDEAD_BEEF;
        dmem_byte_en = 4'b0011;
        dmem_wen     = 1'b1;
        tick();
        checks++; if (ram_addr !== 13'h8 || ram_wen !== 1'b1 || ram_ren !== 1'b0) begin errors++; $display("FAIL wr_drive got %h/%b%b exp 8/01", ram_addr, ram_ren, ram_wen); end
        checks++; if (ram_wdata !== 32'hDEAD_BEEF || ram_byte_en !== 4'b0011) begin errors++; $display("FAIL wr_data got %h/%b exp deadbeef/0011", ram_wdata, ram_byte_en); end
        tick();
        checks++; if (dmem_busy !== 1'b0) begin errors++; $display("FAIL wr_done got %b exp 0", dmem_busy); end
        tick();
        dmem_wen = 1'b0;
        tick();
        lat = 3;
        dmem_ren = 1'b1;
        wait_done(1'b1, 20, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL rd_lat3 got %0d exp 5", cyc); end
        checks++; if (dmem_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL rd_data got %h exp 0000beef", dmem_rdata); end
        tick();
        dmem_ren = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int cyc;
        lat = 0;
        imem_addr = 32'h10;
        dmem_addr = 32'h20;
        imem_ren  = 1'b1;
        dmem_ren  = 1'b1;
        wait_done(1'b1, 10, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL cont_d_lat got %0d exp 2", cyc); end
        checks++; if (dmem_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL cont_d_data got %h exp 0000beef", dmem_rdata); end
        checks++; if (imem_busy !== 1'b1) begin errors++; $display("FAIL cont_i_wait got %b exp 1", imem_busy); end
        tick();
        checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL cont_bubble got %b exp 0", ram_ren); end
        dmem_ren = 1'b0;
        wait_done(1'b0, 10, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL cont_i_lat got %0d exp 2", cyc); end
        checks++; if (imem_rdata !== 32'h4) begin errors++; $display("FAIL cont_i_data got %h exp 4", imem_rdata); end
        tick();
        imem_ren = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d;
        int n;
        logic got_d;
`ifdef RAM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        lat = 0;
        imem_addr = 32'h10;
        dmem_addr = 32'h20;
        imem_ren  = 1'b1;
        dmem_ren  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (imem_busy && dmem_busy && n < 10);
            checks++;
            if (imem_busy && dmem_busy) begin
                errors++;
                $display("FAIL b2b_timeout_%0d got busy 11 exp a completion", k);
            end else begin
                got_d = ~dmem_busy;
                if (got_d !== exp_d[k]) begin errors++; $display("FAIL b2b_grant_%0d got d=%b exp d=%b", k, got_d, exp_d[k]); end
            end
        end
        tick();
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_rw_conflict();
        lat = 0;
        dmem_addr    = 32'h40;
        dmem_wdata   = 32'h1234_5678;
        dmem_byte_en = 4'b1111;
        dmem_ren     = 1'b1;
        dmem_wen     = 1'b1;
        tick();
        checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin errors++; $display("FAIL rw_strobe got ren=%b wen=%b exp 0/1", ram_ren, ram_wen); end
        checks++; if (ram_addr !== 13'h10) begin errors++; $display("FAIL rw_addr got %h exp 10", ram_addr); end
        tick();
        checks++; if (dmem_busy !== 1'b0) begin errors++; $display("FAIL rw_done got %b exp 0", dmem_busy); end
        tick();
        checks++; if (dmem_busy !== 1'b1) begin errors++; $display("FAIL rw_once got %b exp 1", dmem_busy); end
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        lat = 3;
        imem_addr = 32'h10;
        imem_ren  = 1'b1;
        tick();
        tick();
        imem_ren = 1'b0;
        #1;
        checks++; if (imem_busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", imem_busy); end
        tick();
        checks++; if (ram_ren !== 1'b0 || imem_busy !== 1'b1) begin errors++; $display("FAIL abort_idle got %b/%b exp 0/1", ram_ren, imem_busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        lat = 3;
        dmem_addr = 32'h20;
        dmem_ren  = 1'b1;
        tick();
        tick();
        checks++; if (ram_ren !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", ram_ren); end
        nRST     = 1'b0;
        dmem_ren = 1'b0;
        #1;
        checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || ram_addr !== 13'd0) begin errors++; $display("FAIL rst_async got %b%b/%h exp 00/0", ram_ren, ram_wen, ram_addr); end
        checks++; if (dmem_busy !== 1'b1 || imem_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b%b exp 11", imem_busy, dmem_busy); end
        tick();
        nRST = 1'b1;
        tick();
        checks++; if (ram_ren !== 1'b0 || dmem_busy !== 1'b1) begin errors++; $display("FAIL rst_clean got %b/%b exp 0/1", ram_ren, dmem_busy); end
        lat = 0;
        imem_addr = 32'hFFFF_0013;
        imem_ren  = 1'b1;
        tick();
        checks++; if (ram_addr !== 13'h4) begin errors++; $display("FAIL hi_bits_addr got %h exp 4", ram_addr); end
        tick();
        checks++; if (imem_busy !== 1'b0 || imem_rdata !== 32'h4) begin errors++; $display("FAIL post_rst_read got %b/%h exp 0/4", imem_busy, imem_rdata); end
        tick();
        imem_ren = 1'b0;
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        lat          = 0;
        nRST         = 1'b0;
        imem_addr    = '0;
        imem_ren     = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dmem_byte_en = '0;
        dmem_ren     = 1'b0;
        dmem_wen     = 1'b0;
        test_reset();
        test_imem_read();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_rw_conflict();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
